mem_stage_lsu: RTL and testbench

// MEM-stage load/store unit and the consumer end of the EX/MEM pipeline register.

---
 rtl/riscv_mem_pkg.sv | 41 ++++
 rtl/lsu_align.sv | 77 +++++++
 rtl/mem_stage_lsu.sv | 159 +++++++++++++++
 tb/tb_mem_stage_lsu.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : riscv_mem_pkg
// Brief   : Shared encodings for the MEM-stage load/store unit.
// Revision: 1.0 - initial release
// ============================================================================
package riscv_mem_pkg;

    localparam logic [1:0] MEM_CTRL_NONE  = 2'b00;
    localparam logic [1:0] MEM_CTRL_LOAD  = 2'b01;
    localparam logic [1:0] MEM_CTRL_STORE = 2'b10;
    localparam logic [1:0] MEM_CTRL_RSVD  = 2'b11;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } lsu_state_t;

    // Byte enables for an access of size funct3[1:0] at byte offset a.
    function automatic logic [3:0] lane_be(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        case (size)
            2'b00:   be = 4'b0001 << a;
            2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
            default: be = 4'b1111;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module  : lsu_align
// Brief   : Combinational store lane steering, load extraction/extension and
//           misalign/illegal-funct3 detection.
// Revision: 1.0 - initial release
// ============================================================================
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic        is_load,
    input  logic        is_store,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata_lane,
    output logic [31:0] load_data,
    output logic        misaligned,
    output logic        illegal
);

    logic [7:0]  rd_byte;
    logic [15:0] rd_half;

    always_comb begin
        misaligned = 1'b0;
        case (funct3[1:0])
            2'b01:   misaligned = addr_lo[0];
            2'b10:   misaligned = |addr_lo;
            default: misaligned = 1'b0;
        endcase
    end

    always_comb begin
        illegal = 1'b0;
        if (is_load) begin
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end else if (is_store) begin
            illegal = (funct3 >= 3'b011);
        end
    end

    always_comb begin
        be         = lane_be(funct3[1:0], addr_lo);
        wdata_lane = wdata;
        case (funct3[1:0])
            2'b00:   wdata_lane = {4{wdata[7:0]}};
            2'b01:   wdata_lane = {2{wdata[15:0]}};
            default: wdata_lane = wdata;
        endcase
    end

    always_comb begin
        rd_byte = rdata[7:0];
        case (addr_lo)
            2'b00:   rd_byte = rdata[7:0];
            2'b01:   rd_byte = rdata[15:8];
            2'b10:   rd_byte = rdata[23:16];
            default: rd_byte = rdata[31:24];
        endcase
        rd_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        load_data = 32'h0;
        case (funct3)
            F3_LB:   load_data = {{24{rd_byte[7]}}, rd_byte};
            F3_LH:   load_data = {{16{rd_half[15]}}, rd_half};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {24'h0, rd_byte};
            F3_LHU:  load_data = {16'h0, rd_half};
            default: load_data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module  : mem_stage_lsu
// Brief   : MEM-stage load/store unit: req/ack data-memory handshake, pipeline
//           stall generation and ack watchdog.
// Revision: 1.0 - initial release
// ============================================================================
module mem_stage_lsu
    import riscv_mem_pkg::*;
#(
    parameter int ACK_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr_m,
    input  logic [31:0] wdata_m,
    input  logic [2:0]  funct3_m,
    input  logic [1:0]  mem_ctrl_m,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_ack,
    output logic        stall_m,
    output logic [31:0] load_data_m,
    output logic        load_valid_m,
    output logic        access_fault_m
);

    localparam int CNT_W = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((ACK_TIMEOUT > 0) ? ACK_TIMEOUT - 1 : 0);

    lsu_state_t       state;
    lsu_state_t       next_state;
    logic [CNT_W-1:0] tmo_cnt;

    logic        is_load;
    logic        is_store;
    logic        mem_op;
    logic        bad_access;
    logic        access;
    logic        timeout;
    logic        done;
    logic        misaligned;
    logic        illegal;
    logic [3:0]  be_lane;
    logic [31:0] wdata_lane;
    logic [31:0] load_ext;

    lsu_align u_align (
        .addr_lo    (addr_m[1:0]),
        .funct3     (funct3_m),
        .is_load    (is_load),
        .is_store   (is_store),
        .wdata      (wdata_m),
        .rdata      (dmem_rdata),
        .be         (be_lane),
        .wdata_lane (wdata_lane),
        .load_data  (load_ext),
        .misaligned (misaligned),
        .illegal    (illegal)
    );

    assign is_load    = (mem_ctrl_m == MEM_CTRL_LOAD);
    assign is_store   = (mem_ctrl_m == MEM_CTRL_STORE);
    assign mem_op     = is_load | is_store;
    assign bad_access = mem_op & (misaligned | illegal);
    assign access     = mem_op & ~bad_access;

    generate
        if (ACK_TIMEOUT > 0) begin : g_wdog
            assign timeout = (state == BUSY) && !dmem_ack && (tmo_cnt == CNT_LAST);
        end else begin : g_no_wdog
            assign timeout = 1'b0;
        end
    endgenerate

    assign done = dmem_ack | timeout;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Load result is only exposed in the ack cycle so MEM/WB sees zero otherwise.
    always_comb begin
        next_state     = state;
        stall_m        = 1'b0;
        access_fault_m = 1'b0;
        load_valid_m   = 1'b0;
        load_data_m    = 32'h0;
        case (state)
            IDLE: begin
                access_fault_m = bad_access;
                if (access) begin
                    stall_m    = 1'b1;
                    next_state = BUSY;
                end
            end
            BUSY: begin
                stall_m        = ~dmem_ack & ~timeout;
                access_fault_m = timeout;
                if (dmem_ack && !dmem_we) begin
                    load_valid_m = 1'b1;
                    load_data_m  = load_ext;
                end
                if (done) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dmem_req   <= 1'b0;
            dmem_we    <= 1'b0;
            dmem_addr  <= 32'h0;
            dmem_be    <= 4'h0;
            dmem_wdata <= 32'h0;
            tmo_cnt    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    tmo_cnt <= '0;
                    if (access) begin
                        dmem_req   <= 1'b1;
                        dmem_we    <= is_store;
                        dmem_addr  <= {addr_m[31:2], 2'b00};
                        dmem_be    <= be_lane;
                        dmem_wdata <= is_store ? wdata_lane : 32'h0;
                    end
                end
                BUSY: begin
                    if (done) begin
                        dmem_req <= 1'b0;
                        dmem_we  <= 1'b0;
                        tmo_cnt  <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    dmem_req <= 1'b0;
                    dmem_we  <= 1'b0;
                    tmo_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_stage_lsu
// Brief   : Self-checking bench for mem_stage_lsu against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] addr_m;
    logic [31:0] wdata_m;
    logic [2:0]  funct3_m;
    logic [1:0]  mem_ctrl_m;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;
    logic        stall_m;
    logic [31:0] load_data_m;
    logic        load_valid_m;
    logic        access_fault_m;

    int n_tests = 0;
    int n_fail  = 0;

    mem_stage_lsu #(.ACK_TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .addr_m         (addr_m),
        .wdata_m        (wdata_m),
        .funct3_m       (funct3_m),
        .mem_ctrl_m     (mem_ctrl_m),
        .dmem_req       (dmem_req),
        .dmem_we        (dmem_we),
        .dmem_addr      (dmem_addr),
        .dmem_be        (dmem_be),
        .dmem_wdata     (dmem_wdata),
        .dmem_rdata     (dmem_rdata),
        .dmem_ack       (dmem_ack),
        .stall_m        (stall_m),
        .load_data_m    (load_data_m),
        .load_valid_m   (load_valid_m),
        .access_fault_m (access_fault_m)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int acc_size(input logic [2:0] f3);
        return 1 << f3[1:0];
    endfunction

    function automatic bit model_legal(input logic [1:0] ctrl, input logic [2:0] f3, input logic [31:0] a);
        bit ok_f3;
        if (ctrl == 2'b01)      ok_f3 = (f3 == 0) || (f3 == 1) || (f3 == 2) || (f3 == 4) || (f3 == 5);
        else if (ctrl == 2'b10) ok_f3 = (f3 <= 2);
        else                    ok_f3 = 1'b0;
        return ok_f3 && ((a % acc_size(f3)) == 0);
    endfunction

    function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] a);
        int sz = acc_size(f3);
        int m  = ((1 << sz) - 1) << (a % 4);
        return 32'(m & 15);
    endfunction

    function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] wd);
        int sz = acc_size(f3);
        if (sz == 1) return (wd & 32'hFF) * 32'h01010101;
        if (sz == 2) return (wd & 32'hFFFF) * 32'h00010001;
        return wd;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
        int          sz   = acc_size(f3);
        logic [31:0] mask = (sz == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * sz)) - 32'd1);
        logic [31:0] v    = (rd >> (8 * (a % 4))) & mask;
        if (f3 < 4 && sz < 4 && v >= (32'd1 << (8 * sz - 1))) v = v | ~mask;
        return v;
    endfunction

    // One instruction presented in MEM; delay = BUSY cycles before ack (>=TMO means never).
    task automatic run_access(input logic [1:0] ctrl, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int delay,
                              input bit tail);
        bit is_ld = (ctrl == 2'b01);
        bit is_st = (ctrl == 2'b10);
        @(negedge clk);
        mem_ctrl_m = ctrl; funct3_m = f3; addr_m = a; wdata_m = wd;
        dmem_rdata = rd;   dmem_ack = 1'b0;
        #1;
        if (!is_ld && !is_st) begin
            check("bubble_stall", 32'(stall_m), 32'd0);
            check("bubble_fault", 32'(access_fault_m), 32'd0);
        end else if (!model_legal(ctrl, f3, a)) begin
            check("bad_fault", 32'(access_fault_m), 32'd1);
            check("bad_stall", 32'(stall_m), 32'd0);
            check("bad_req",   32'(dmem_req), 32'd0);
        end else begin
            check("idle_stall", 32'(stall_m), 32'd1);
            check("idle_fault", 32'(access_fault_m), 32'd0);
            check("idle_req",   32'(dmem_req), 32'd0);
            for (int i = 0; i < TMO; i++) begin
                @(negedge clk);
                dmem_ack = (i == delay);
                #1;
                check("busy_req",  32'(dmem_req), 32'd1);
                check("busy_we",   32'(dmem_we), 32'(is_st));
                check("busy_addr", dmem_addr, a & 32'hFFFFFFFC);
                if (is_st) begin
                    check("st_be",    32'(dmem_be), model_be(f3, a));
                    check("st_wdata", dmem_wdata, model_wdata(f3, a == a ? wd : wd));
                end
                if (i == delay) begin
                    check("ack_stall", 32'(stall_m), 32'd0);
                    check("ack_fault", 32'(access_fault_m), 32'd0);
                    check("ack_lvalid", 32'(load_valid_m), 32'(is_ld));
                    if (is_ld) check("ld_data", load_data_m, model_load(f3, a, rd));
                    break;
                end else if (i == TMO - 1) begin
                    check("tmo_fault",  32'(access_fault_m), 32'd1);
                    check("tmo_stall",  32'(stall_m), 32'd0);
                    check("tmo_lvalid", 32'(load_valid_m), 32'd0);
                end else begin
                    check("wait_stall", 32'(stall_m), 32'd1);
                    check("wait_fault", 32'(access_fault_m), 32'd0);
                end
            end
        end
        if (tail) begin
            @(negedge clk);
            dmem_ack = 1'b0; mem_ctrl_m = 2'b00;
            #1;
            check("post_req",   32'(dmem_req), 32'd0);
            check("post_stall", 32'(stall_m), 32'd0);
        end
    endtask

    initial begin
        rst_n = 1'b0; addr_m = '0; wdata_m = '0; funct3_m = '0; mem_ctrl_m = '0;
        dmem_rdata = '0; dmem_ack = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req",    32'(dmem_req), 32'd0);
        check("rst_we",     32'(dmem_we), 32'd0);
        check("rst_addr",   dmem_addr, 32'd0);
        check("rst_be",     32'(dmem_be), 32'd0);
        check("rst_wdata",  dmem_wdata, 32'd0);
        check("rst_stall",  32'(stall_m), 32'd0);
        check("rst_lvalid", 32'(load_valid_m), 32'd0);
        check("rst_ldata",  load_data_m, 32'd0);
        check("rst_fault",  32'(access_fault_m), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed cases.
        run_access(2'b10, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 1'b1);
        run_access(2'b10, 3'b000, 32'h103, 32'h000000A5, 32'h0, 0, 1'b1);
        run_access(2'b01, 3'b000, 32'h102, 32'h0, 32'h00800000, 2, 1'b1);
        run_access(2'b01, 3'b100, 32'h102, 32'h0, 32'h00800000, 2, 1'b1);
        run_access(2'b01, 3'b001, 32'h101, 32'h0, 32'h0, 0, 1'b1);
        run_access(2'b10, 3'b010, 32'h102, 32'h12345678, 32'h0, 0, 1'b1);
        run_access(2'b10, 3'b011, 32'h100, 32'h12345678, 32'h0, 0, 1'b1);
        run_access(2'b11, 3'b010, 32'h100, 32'h12345678, 32'h0, 0, 1'b1);

        // Timeout followed by a late ack that must be ignored.
        run_access(2'b01, 3'b010, 32'h300, 32'h0, 32'hCAFEF00D, 99, 1'b0);
        @(negedge clk);
        mem_ctrl_m = 2'b00; dmem_ack = 1'b1;
        #1;
        check("late_ack_lvalid", 32'(load_valid_m), 32'd0);
        check("late_ack_stall",  32'(stall_m), 32'd0);
        check("late_ack_req",    32'(dmem_req), 32'd0);
        @(negedge clk);
        dmem_ack = 1'b0;
        #1;
        check("late_ack_req2", 32'(dmem_req), 32'd0);

        // Async reset while BUSY.
        @(negedge clk);
        mem_ctrl_m = 2'b01; funct3_m = 3'b010; addr_m = 32'h200;
        @(negedge clk);
        #1;
        check("pre_rst_req", 32'(dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_rst_req",    32'(dmem_req), 32'd0);
        check("async_rst_lvalid", 32'(load_valid_m), 32'd0);
        mem_ctrl_m = 2'b00;
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back LW then SW.
        run_access(2'b01, 3'b010, 32'h400, 32'h0, 32'h89ABCDEF, 1, 1'b0);
        run_access(2'b10, 3'b001, 32'h406, 32'h0000BEEF, 32'h0, 0, 1'b1);

        // Randomized accesses.
        for (int k = 0; k < 60; k++) begin
            logic [1:0]  c  = 2'($urandom_range(0, 3));
            logic [2:0]  f  = 3'($urandom_range(0, 7));
            logic [31:0] ad = $urandom;
            logic [31:0] wd = $urandom;
            logic [31:0] rd = $urandom;
            int          d  = $urandom_range(0, 5);
            if ($urandom_range(0, 1) == 1) ad[1:0] = 2'b00;
            run_access(c, f, ad, wd, rd, d, 1'($urandom_range(0, 1)));
        end

        @(negedge clk);
        mem_ctrl_m = 2'b00; dmem_ack = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
